// File: rtl/pair_sum_xfer.sv
// Reads 8 words from MemoryA, writes the 4 adjacent-pair sums (mod 256) to MemoryB with a sticky carry flag.
// Optional output Checksum (mod-256 sum of written bytes) is included when XFER_CHECKSUM_EN is defined.
module pair_sum_xfer #(
  parameter int AW_A = 3,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  output logic [AW_A-1:0] AddrA,
  output logic            WEA,
  input  logic [DW-1:0]   DataOutA,
  output logic [AW_A-2:0] AddrB,
  output logic            WEB,
  output logic [DW-1:0]   DataInB,
  output logic            Busy,
  output logic            Done,
`ifdef XFER_CHECKSUM_EN
  output logic [DW-1:0]   Checksum,
`endif
  output logic            Overflow
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ0 = 3'd1,
    READ1 = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AW_A-2:0]   k_q, k_d;
  logic [DW-1:0]     op0_q, op0_d, op1_q, op1_d;
  logic              ovf_q, ovf_d;
  logic [DW:0]       sum_w;

  // Carry-preserving add: bit DW is the carry out of the pair sum.
  function automatic logic [DW:0] pair_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign sum_w = pair_add(op0_q, op1_q);

`ifdef XFER_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    ovf_d   = ovf_q;
`ifdef XFER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = READ0;
          k_d     = '0;
          ovf_d   = 1'b0;
`ifdef XFER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      READ0: begin
        op0_d   = DataOutA;
        state_d = READ1;
      end
      READ1: begin
        op1_d   = DataOutA;
        state_d = WRITE;
      end
      WRITE: begin
        if (sum_w[DW]) ovf_d = 1'b1;
`ifdef XFER_CHECKSUM_EN
        csum_d = csum_q + sum_w[DW-1:0];
`endif
        if (k_q == '1) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = READ0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      op0_q   <= '0;
      op1_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef XFER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      ovf_q   <= ovf_d;
`ifdef XFER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Outputs decode from registered state only; Start and DataOutA never reach them combinationally.
  always_comb begin
    AddrA = '0;
    if (state_q == READ0) AddrA = {k_q, 1'b0};
    if (state_q == READ1) AddrA = {k_q, 1'b1};
  end

  assign WEA      = 1'b0;
  assign AddrB    = k_q;
  assign WEB      = (state_q == WRITE);
  assign DataInB  = (state_q == WRITE) ? sum_w[DW-1:0] : '0;
  assign Busy     = (state_q == READ0) || (state_q == READ1) || (state_q == WRITE);
  assign Done     = (state_q == DONE);
  assign Overflow = ovf_q;
`ifdef XFER_CHECKSUM_EN
  assign Checksum = csum_q;
`endif

endmodule

// File: tb/tb_pair_sum_xfer.sv
// Bench for pair_sum_xfer: transfer-timeline reference model, per-cycle output compare, directed and random transfers.
module tb_pair_sum_xfer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Start;
  logic [2:0] AddrA;
  logic       WEA;
  logic [7:0] DataOutA;
  logic [1:0] AddrB;
  logic       WEB;
  logic [7:0] DataInB;
  logic       Busy, Done, Overflow;
`ifdef XFER_CHECKSUM_EN
  logic [7:0] Checksum;
`endif

  logic [7:0] memA [8];
  logic [7:0] memB [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int web_cnt = 0;

  // Reference model: off = cycle offset since accepting edge (1..13), -1 when idle.
  int         off;
  logic [7:0] es [4];
  logic       ec [4];
  logic       eovf;
  logic [7:0] ecs;

  pair_sum_xfer #(.AW_A(3), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start),
    .AddrA(AddrA), .WEA(WEA), .DataOutA(DataOutA),
    .AddrB(AddrB), .WEB(WEB), .DataInB(DataInB),
    .Busy(Busy), .Done(Done),
`ifdef XFER_CHECKSUM_EN
    .Checksum(Checksum),
`endif
    .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  assign DataOutA = memA[AddrA];

  always @(posedge clk) begin
    cyc++;
    if (rst_n && WEB) begin
      memB[AddrB] = DataInB;
      web_cnt++;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off  = -1;
      eovf = 1'b0;
      ecs  = 8'h00;
    end else if (off < 0) begin
      if (Start) begin
        off  = 1;
        eovf = 1'b0;
        ecs  = 8'h00;
        for (int p = 0; p < 4; p++) begin
          int s;
          s     = int'(memA[2*p]) + int'(memA[2*p+1]);
          es[p] = 8'(s % 256);
          ec[p] = (s > 255);
        end
      end
    end else begin
      if (off % 3 == 0 && off <= 12) begin
        eovf = eovf | ec[off/3 - 1];
        ecs  = 8'(ecs + es[off/3 - 1]);
      end
      off = (off == 13) ? -1 : off + 1;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy", Busy, (off >= 1 && off <= 12));
      chk("done", Done, (off == 13));
      chk("web",  WEB,  (off >= 1 && off <= 12 && off % 3 == 0));
      chk("wea",  WEA,  0);
      chk("overflow", Overflow, eovf);
`ifdef XFER_CHECKSUM_EN
      chk("checksum", Checksum, ecs);
`endif
      if (off < 0) chk("addra_idle", AddrA, 0);
      else if (off <= 12 && off % 3 == 1) chk("addra_rd0", AddrA, 2*((off-1)/3));
      else if (off <= 12 && off % 3 == 2) chk("addra_rd1", AddrA, 2*((off-1)/3) + 1);
      if (off >= 1 && off <= 12 && off % 3 == 0) begin
        chk("addrb",   AddrB,   off/3 - 1);
        chk("datainb", DataInB, es[off/3 - 1]);
      end
    end
  end

  task automatic load_a(input logic [63:0] v);
    for (int i = 0; i < 8; i++) memA[i] = v[63-8*i -: 8];
  endtask

  task automatic clear_b();
    for (int i = 0; i < 4; i++) memB[i] = 8'h55;
  endtask

  task automatic chk_b(input string n, input logic [31:0] v);
    for (int i = 0; i < 4; i++) chk(n, memB[i], v[31-8*i -: 8]);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (off < 0) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_off(input int v);
    for (int i = 0; i < 40; i++) begin
      if (off == v) return;
      @(negedge clk);
    end
    chk("offset_timeout", off, v);
  endtask

  task automatic run_one(output int lat);
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    wait_idle();
  endtask

  initial begin
    int lat;
    int dn;
    int q[$];

    rst_n = 1'b0;
    Start = 1'b0;
    load_a(64'h0);
    clear_b();
    repeat (3) @(negedge clk);
    chk("rst_addra", AddrA, 0);
    chk("rst_addrb", AddrB, 0);
    chk("rst_web", WEB, 0);
    chk("rst_datainb", DataInB, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_overflow", Overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reference pattern with one carry.
    load_a(64'h2387B7D711C18507);
    clear_b();
    run_one(lat);
    chk("lat_done", lat, 13);
    chk_b("b_pattern", 32'hAA8ED28C);
    chk("ovf_pattern", Overflow, 1);
`ifdef XFER_CHECKSUM_EN
    chk("cs_pattern", Checksum, 8'h96);
`endif

    // All zero: four writes covering every B address.
    load_a(64'h0);
    clear_b();
    web_cnt = 0;
    run_one(lat);
    chk("web_count", web_cnt, 4);
    chk_b("b_zero", 32'h00000000);
    chk("ovf_zero", Overflow, 0);
`ifdef XFER_CHECKSUM_EN
    chk("cs_zero", Checksum, 8'h00);
`endif

    // All ones: every pair carries.
    load_a(64'hFFFFFFFFFFFFFFFF);
    clear_b();
    run_one(lat);
    chk_b("b_ff", 32'hFEFEFEFE);
    chk("ovf_ff", Overflow, 1);
`ifdef XFER_CHECKSUM_EN
    chk("cs_ff", Checksum, 8'hF8);
`endif

    // Start pulse during READ1 of pair 1 must be ignored.
    load_a(64'h0102030405060708);
    clear_b();
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_off(5);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      if (Done === 1'b1) dn++;
      @(negedge clk);
    end
    chk("single_done", dn, 1);
    chk_b("b_ignore", 32'h03070B0F);

    // Start held high: back-to-back transfers every 14 cycles.
    load_a(64'h2387B7D711C18507);
    @(negedge clk);
    Start = 1'b1;
    for (int i = 0; i < 47; i++) begin
      @(negedge clk);
      if (Done === 1'b1) q.push_back(cyc);
    end
    Start = 1'b0;
    wait_idle();
    chk("held_done_cnt", q.size(), 3);
    if (q.size() == 3) begin
      chk("held_period0", q[1] - q[0], 14);
      chk("held_period1", q[2] - q[1], 14);
    end

    // Reset during READ0 of pair 1.
    load_a(64'h2387B7D711C18507);
    clear_b();
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_off(4);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_web", WEB, 0);
    chk("rstmid_busy", Busy, 0);
    chk("rstmid_ovf", Overflow, 0);
    @(negedge clk);
    @(negedge clk);
    chk_b("b_rstmid", 32'hAA555555);
    rst_n = 1'b1;
    run_one(lat);
    chk("lat_after_rst", lat, 13);
    chk_b("b_after_rst", 32'hAA8ED28C);

    // Random data with spurious Start activity during transfers.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 8; i++) memA[i] = 8'($urandom_range(0, 255));
      clear_b();
      web_cnt = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      Start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 40 && off > 0; i++) begin
        Start = (off < 13) ? ($urandom_range(0, 2) == 0) : 1'b0;
        @(negedge clk);
      end
      Start = 1'b0;
      wait_idle();
      chk("rnd_web_count", web_cnt, 4);
      for (int i = 0; i < 4; i++) chk("rnd_b", memB[i], es[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule
